renee_wheel_driver: RTL and testbench

//  Downstream stage of the Renee navigation logic. It consumes the one-hot wheel actions
//  lwa/rwa (100=F, 010=R, 001=S) and converts them into per-wheel PWM enable and direction.
//  - Soft-start ramp when a wheel begins moving.
//  - Mandatory dead time on every stop or reversal.
//  - Sticky fault flag for illegal action codes.

---
 rtl/renee_wheel_driver_pkg.sv | 12 +
 rtl/renee_wheel_driver_if.sv | 19 +
 rtl/renee_wheel_driver_channel.sv | 81 ++++++++
 rtl/renee_wheel_driver.sv | 28 ++
 tb/tb_renee_wheel_driver.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/renee_wheel_driver_pkg.sv
// renee_wheel_driver_pkg: action codes and channel state encoding shared by the wheel driver
package renee_wheel_driver_pkg;
    localparam logic [2:0] ACT_F = 3'b100;
    localparam logic [2:0] ACT_R = 3'b010;
    localparam logic [2:0] ACT_S = 3'b001;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RAMP = 3'd1,
        ST_RUN  = 3'd2,
        ST_DEAD = 3'd3
    } state_t;
endpackage

// File: rtl/renee_wheel_driver_if.sv
// renee_wheel_driver_if: wheel command inputs and motor/status outputs of the wheel driver
interface renee_wheel_driver_if import renee_wheel_driver_pkg::*; ();
    logic       en;
    logic [2:0] lwa;
    logic [2:0] rwa;
    logic       l_pwm;
    logic       l_dir;
    logic       r_pwm;
    logic       r_dir;
    state_t     l_state;
    state_t     r_state;
    logic       l_fault;
    logic       r_fault;
    logic       moving;
    modport master (output en, lwa, rwa,
                    input  l_pwm, l_dir, r_pwm, r_dir, l_state, r_state, l_fault, r_fault, moving);
    modport slave  (input  en, lwa, rwa,
                    output l_pwm, l_dir, r_pwm, r_dir, l_state, r_state, l_fault, r_fault, moving);
endinterface

// File: rtl/renee_wheel_driver_channel.sv
// renee_wheel_channel: one wheel's decode, soft-start/dead-time FSM, fault flag and PWM compare
module renee_wheel_channel import renee_wheel_driver_pkg::*; #(
    parameter int PWM_BITS         = 4,
    parameter int DEAD_CYCLES      = 8,
    parameter int RAMP_STEP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          act,
    input  logic [PWM_BITS-1:0] cnt,
    output logic                pwm,
    output logic                dir,
    output logic                fault,
    output state_t              state
);
    localparam int SW = $clog2(RAMP_STEP_CYCLES) + 1;
    localparam int DW = $clog2(DEAD_CYCLES) + 1;
    localparam logic [PWM_BITS-1:0] DMAX = '1;
    logic [PWM_BITS-1:0] duty, duty_n;
    logic [SW-1:0] step, step_n;
    logic [DW-1:0] dead, dead_n;
    state_t state_n;
    logic dir_n;
    logic want_f, want_r, go, same, illegal;
    assign want_f  = act == ACT_F;
    assign want_r  = act == ACT_R;
    assign go      = want_f | want_r;
    assign same    = dir ? want_f : want_r;
    assign illegal = !go && act != ACT_S;
    always_comb begin
        state_n = state;
        duty_n  = duty;
        step_n  = step;
        dead_n  = dead;
        dir_n   = dir;
        case (state)
            ST_IDLE: if (go) begin
                state_n = ST_RAMP;
                dir_n   = want_f;
                duty_n  = '0;
                step_n  = '0;
            end
            ST_RAMP, ST_RUN: if (!same) begin
                state_n = ST_DEAD;
                duty_n  = '0;
                dead_n  = DW'(DEAD_CYCLES - 1);
            end else if (state == ST_RAMP) begin
                if (step == SW'(RAMP_STEP_CYCLES - 1)) begin
                    step_n  = '0;
                    duty_n  = duty + PWM_BITS'(1);
                    state_n = (duty == DMAX - PWM_BITS'(1)) ? ST_RUN : ST_RAMP;
                end else begin
                    step_n = step + SW'(1);
                end
            end
            default: begin
                state_n = (dead == '0) ? ST_IDLE : ST_DEAD;
                dead_n  = (dead == '0) ? dead : dead - DW'(1);
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            duty  <= '0;
            step  <= '0;
            dead  <= '0;
            dir   <= 1'b0;
            fault <= 1'b0;
            pwm   <= 1'b0;
        end else begin
            state <= state_n;
            duty  <= duty_n;
            step  <= step_n;
            dead  <= dead_n;
            dir   <= dir_n;
            fault <= fault | illegal;
            pwm   <= (duty == DMAX) | (cnt < duty);
        end
    end
endmodule

// File: rtl/renee_wheel_driver.sv
// renee_wheel_driver: two independent wheel channels sharing one free-running PWM counter
module renee_wheel_driver import renee_wheel_driver_pkg::*; #(
    parameter int PWM_BITS         = 4,
    parameter int DEAD_CYCLES      = 8,
    parameter int RAMP_STEP_CYCLES = 4
) (
    input logic            clk,
    input logic            rst,
    renee_wheel_driver_if.slave bus
);
    logic [PWM_BITS-1:0] cnt;
    logic [2:0] l_act, r_act;
    always_ff @(posedge clk) begin
        cnt <= rst ? '0 : cnt + PWM_BITS'(1);
    end
    // disabling is a plain stop, never a fault
    assign l_act = bus.en ? bus.lwa : ACT_S;
    assign r_act = bus.en ? bus.rwa : ACT_S;
    renee_wheel_channel #(.PWM_BITS(PWM_BITS), .DEAD_CYCLES(DEAD_CYCLES), .RAMP_STEP_CYCLES(RAMP_STEP_CYCLES)) u_left (
        .clk(clk), .rst(rst), .act(l_act), .cnt(cnt),
        .pwm(bus.l_pwm), .dir(bus.l_dir), .fault(bus.l_fault), .state(bus.l_state)
    );
    renee_wheel_channel #(.PWM_BITS(PWM_BITS), .DEAD_CYCLES(DEAD_CYCLES), .RAMP_STEP_CYCLES(RAMP_STEP_CYCLES)) u_right (
        .clk(clk), .rst(rst), .act(r_act), .cnt(cnt),
        .pwm(bus.r_pwm), .dir(bus.r_dir), .fault(bus.r_fault), .state(bus.r_state)
    );
    assign bus.moving = bus.l_state inside {ST_RAMP, ST_RUN} || bus.r_state inside {ST_RAMP, ST_RUN};
endmodule

// File: tb/tb_renee_wheel_driver.sv
// tb_renee_wheel_driver: directed and random stimulus against a time-based wheel model
module tb_renee_wheel_driver;
    localparam logic [2:0] F = 3'b100, R = 3'b010, S = 3'b001;
    localparam int IDLE = 0, RAMP = 1, RUN = 2, DEAD = 3;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    int mode[2], tin[2], mcnt;
    bit mdir[2], mfault[2], mpwm[2];
    renee_wheel_driver_if bus();
    renee_wheel_driver dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // duty follows from elapsed time: one step per 4 cycles of ramp, full in RUN
    function automatic int duty_of(int w);
        return mode[w] == RAMP ? tin[w] / 4 : mode[w] == RUN ? 15 : 0;
    endfunction

    task automatic model(input logic [2:0] l, input logic [2:0] r, input logic e, input logic rs);
        logic [2:0] a[2];
        a[0] = e ? l : S;
        a[1] = e ? r : S;
        if (rs) begin
            for (int w = 0; w < 2; w++) begin
                mode[w] = IDLE; tin[w] = 0; mdir[w] = 0; mfault[w] = 0; mpwm[w] = 0;
            end
            mcnt = 0;
            return;
        end
        for (int w = 0; w < 2; w++) begin
            automatic int d = duty_of(w);
            automatic bit mv = a[w] == F || a[w] == R;
            automatic bit keep = mv && ((a[w] == F) == mdir[w]);
            mpwm[w] = d == 15 || mcnt < d;
            if (!(mv || a[w] == S)) mfault[w] = 1;
            case (mode[w])
                IDLE: if (mv) begin mode[w] = RAMP; tin[w] = 0; mdir[w] = a[w] == F; end
                RAMP: if (!keep) begin mode[w] = DEAD; tin[w] = 0; end
                      else begin tin[w]++; if (tin[w] == 60) mode[w] = RUN; end
                RUN:  if (!keep) begin mode[w] = DEAD; tin[w] = 0; end
                default: begin tin[w]++; if (tin[w] == 8) begin mode[w] = IDLE; tin[w] = 0; end end
            endcase
        end
        mcnt = (mcnt + 1) % 16;
    endtask

    task automatic tick(input logic [2:0] l, input logic [2:0] r, input logic e, input logic rs);
        rst = rs; bus.en = e; bus.lwa = l; bus.rwa = r;
        @(posedge clk);
        model(l, r, e, rs);
        #1;
        chk("l_state", 32'(bus.l_state), 32'(mode[0]));
        chk("r_state", 32'(bus.r_state), 32'(mode[1]));
        chk("l_pwm", 32'(bus.l_pwm), 32'(mpwm[0]));
        chk("r_pwm", 32'(bus.r_pwm), 32'(mpwm[1]));
        chk("l_dir", 32'(bus.l_dir), 32'(mdir[0]));
        chk("r_dir", 32'(bus.r_dir), 32'(mdir[1]));
        chk("l_fault", 32'(bus.l_fault), 32'(mfault[0]));
        chk("r_fault", 32'(bus.r_fault), 32'(mfault[1]));
        chk("moving", 32'(bus.moving), 32'(mode[0] inside {RAMP, RUN} || mode[1] inside {RAMP, RUN}));
    endtask

    task automatic run(input int n, input logic [2:0] l, input logic [2:0] r, input logic e);
        for (int i = 0; i < n; i++) tick(l, r, e, 1'b0);
    endtask

    initial begin
        int hi;
        logic [2:0] codes[8];
        codes = '{F, R, S, F, R, S, 3'b000, 3'b110};
        tick(S, S, 1, 1);
        tick(S, S, 1, 1);
        chk("reset_state", 32'(bus.l_state), 0);
        run(1, F, F, 1);
        chk("t1_ramp", 32'(bus.l_state), RAMP);
        chk("t1_dir", 32'(bus.l_dir), 1);
        run(59, F, F, 1);
        chk("t1_not_yet_run", 32'(bus.r_state), RAMP);
        run(1, F, F, 1);
        chk("t1_run_at_60", 32'(bus.r_state), RUN);
        hi = 0;
        for (int i = 0; i < 16; i++) begin tick(F, F, 1, 0); hi += int'(bus.l_pwm); end
        chk("t1_pwm_solid", hi, 16);
        run(1, R, F, 1);
        chk("t2_dead", 32'(bus.l_state), DEAD);
        run(7, R, F, 1);
        chk("t2_dead_dir", 32'(bus.l_dir), 1);
        run(1, R, F, 1);
        chk("t2_idle", 32'(bus.l_state), IDLE);
        run(1, R, F, 1);
        chk("t2_ramp_rev", 32'(bus.l_dir), 0);
        chk("t2_right_run", 32'(bus.r_state), RUN);
        run(10, R, S, 1);
        run(21, R, F, 1);
        run(1, R, S, 1);
        chk("t3_dead", 32'(bus.r_state), DEAD);
        run(8, R, F, 1);
        chk("t3_idle", 32'(bus.r_state), IDLE);
        run(1, R, F, 1);
        chk("t3_ramp", 32'(bus.r_state), RAMP);
        run(1, 3'b110, F, 1);
        chk("t4_fault", 32'(bus.l_fault), 1);
        run(1, 3'b000, F, 1);
        run(12, F, F, 1);
        chk("t4_sticky", 32'(bus.l_fault), 1);
        tick(S, S, 1, 1);
        run(61, F, F, 1);
        run(10, F, F, 0);
        chk("t5_moving", 32'(bus.moving), 0);
        chk("t5_nofault", 32'(bus.r_fault), 0);
        run(61, F, R, 1);
        run(3, S, S, 1);
        tick(S, S, 1, 1);
        chk("t6_reset_dead", 32'(bus.l_state), IDLE);
        run(10, R, F, 1);
        tick(R, F, 1, 1);
        chk("t6_reset_ramp", 32'(bus.moving), 0);
        run(20, R, F, 1);
        for (int seg = 0; seg < 300; seg++) begin
            logic [2:0] l, r;
            logic e;
            l = codes[$urandom_range(7)];
            r = codes[$urandom_range(7)];
            e = $urandom_range(9) != 0;
            if ($urandom_range(39) == 0) tick(l, r, e, 1);
            run($urandom_range(80, 1), l, r, e);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
